// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
// Contents: FSM state enum, column strobe encoding, key map, row priority helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB_PRESS,
        ST_PRESSED,
        ST_DEB_REL
    } kp_state_e;

    // Active-low one-hot column strobes, indexed by column number.
    localparam logic [3:0] COL_STROBE_N [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // KEYMAP[row][col]
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    // Dwell periods between auto-repeat keys while a key is held.
    localparam int REPEAT_DWELLS = 16;

    // Lowest-numbered low row wins when several rows are pressed together.
    function automatic logic [1:0] low_row_idx(input logic [3:0] rows_n);
        if (!rows_n[0]) return 2'd0;
        if (!rows_n[1]) return 2'd1;
        if (!rows_n[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/kp_sync.sv
// rtl/kp_sync.sv - 4-bit two-flop synchronizer, resets to all ones
// Ports: clk, clr_n (async active-low), d (asynchronous in), q (synchronized out).
module kp_sync (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and valid/ready key output
// Ports: clk, clr_n (async active-low), row_n (async row sense), col_n (column strobe),
//        key_code/key_valid/key_ready (key handshake), key_held, overrun (sticky).
// Build option: KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 8
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_N - 1);

    kp_state_e        state, state_nxt;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic [3:0]       first_n;
    logic             dwell_end, any_low;
    logic             adv_col, capture, accept, rel_done;
    logic [3:0]       accept_code;

    kp_sync u_sync (
        .clk   (clk),
        .clr_n (clr_n),
        .d     (row_n),
        .q     (row_sync)
    );

    assign dwell_end = (div_cnt == DIV_LAST);
    assign any_low   = ~&row_sync;
    assign col_n     = COL_STROBE_N[col_idx];

`ifdef KEYPAD_REPEAT_EN
    logic [3:0] rep_cnt;
    logic       rep_fire;
    assign rep_fire = dwell_end && (rep_cnt == 4'(REPEAT_DWELLS - 1));

    // Counts dwell periods spent in PRESSED; restarts whenever PRESSED is left or a repeat fires.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rep_cnt <= '0;
        end else if (state != ST_PRESSED || state_nxt != ST_PRESSED || rep_fire) begin
            rep_cnt <= '0;
        end else if (dwell_end) begin
            rep_cnt <= rep_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= ST_SCAN;
        else        state <= state_nxt;
    end

    // Every decision happens at a dwell-end sample; the first sample of a
    // candidate press counts toward the DEBOUNCE_N run.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        adv_col     = 1'b0;
        capture     = 1'b0;
        accept      = 1'b0;
        rel_done    = 1'b0;
        accept_code = KEYMAP[low_row_idx(row_sync)][col_idx];
        if (dwell_end) begin
            case (state)
                ST_SCAN: begin
                    if (any_low) begin
                        capture = 1'b1;
                        if (DEBOUNCE_N <= 1) begin
                            accept    = 1'b1;
                            state_nxt = ST_PRESSED;
                        end else begin
                            state_nxt   = ST_DEB_PRESS;
                            deb_cnt_nxt = DEB_W'(1);
                        end
                    end else begin
                        adv_col = 1'b1;
                    end
                end
                ST_DEB_PRESS: begin
                    if (row_sync != first_n) begin
                        state_nxt   = ST_SCAN;
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        accept      = 1'b1;
                        state_nxt   = ST_PRESSED;
                        deb_cnt_nxt = '0;
                    end else begin
                        deb_cnt_nxt = deb_cnt + DEB_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!any_low) begin
                        if (DEBOUNCE_N <= 1) begin
                            state_nxt = ST_SCAN;
                            rel_done  = 1'b1;
                        end else begin
                            state_nxt   = ST_DEB_REL;
                            deb_cnt_nxt = DEB_W'(1);
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_fire) begin
                        accept      = 1'b1;
                        accept_code = key_code;
                    end
`endif
                end
                ST_DEB_REL: begin
                    if (any_low) begin
                        state_nxt   = ST_PRESSED;
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt   = ST_SCAN;
                        rel_done    = 1'b1;
                        deb_cnt_nxt = '0;
                    end else begin
                        deb_cnt_nxt = deb_cnt + DEB_W'(1);
                    end
                end
                default: begin
                    state_nxt   = ST_SCAN;
                    deb_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_cnt   <= '0;
            col_idx   <= 2'd0;
            deb_cnt   <= '0;
            first_n   <= 4'hF;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            div_cnt <= dwell_end ? '0 : div_cnt + DIV_W'(1);
            deb_cnt <= deb_cnt_nxt;
            if (adv_col) col_idx <= col_idx + 2'd1;
            if (capture) first_n <= row_sync;
            // A new key beats a same-edge handshake; overwriting an unconsumed key is an overrun.
            if (accept) begin
                key_code  <= accept_code;
                key_valid <= 1'b1;
                if (key_valid && !key_ready) overrun <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (accept)        key_held <= 1'b1;
            else if (rel_done) key_held <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan
module tb_keypad_scan;

    localparam int SD  = 4;
    localparam int DN  = 3;
    localparam int LAT = 2 + SD * (DN + 4);
    localparam logic [3:0] COLS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam int KM [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       key_ready = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       overrun;
    logic [15:0] pressed = 16'h0;

    int total = 0;
    int bad = 0;
    logic [3:0] got [$];

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_N(DN)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is strobed.
    always @* begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            if (col_n == COLS[c])
                for (int r = 0; r < 4; r++)
                    if (pressed[r*4+c]) row_n[r] = 1'b0;
    end

    // Records every key the consumer takes.
    always @(negedge clk)
        if (clr_n && key_valid === 1'b1 && key_ready) got.push_back(key_code);

    function automatic logic [3:0] ref_code(input logic [15:0] p, input int c);
        for (int r = 0; r < 4; r++)
            if (p[r*4+c]) return 4'(KM[r*4+c]);
        return 4'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic finish_press(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, (n <= LAT), 1);
        step(20);
        chk({tag, "_held"}, key_held, 1);
        pressed = 16'h0;
        step(40);
        chk({tag, "_released"}, key_held, 0);
        chk({tag, "_count"}, got.size(), 1);
        chk({tag, "_code"}, (got.size() > 0) ? got[0] : 4'hx, exp);
        chk({tag, "_valid_clr"}, key_valid, 0);
    endtask

    task automatic press_test(input string tag, input logic [3:0] rmask, input int c);
        got.delete();
        for (int r = 0; r < 4; r++)
            if (rmask[r]) pressed[r*4+c] = 1'b1;
        finish_press(tag, ref_code(pressed, c));
    endtask

    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (col_n !== COLS[c] && n < 100) begin
            step(1);
            n++;
        end
        chk("col_wait", (n < 100), 1);
    endtask

    initial begin
        step(3);
        chk("rst_col", col_n, 4'b1110);
        chk("rst_code", key_code, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        chk("rst_overrun", overrun, 0);
        clr_n = 1'b1;
        step(10);

        press_test("single_key3", 4'b0001, 2);
        press_test("dual_row_col1", 4'b0101, 1);

        // Bouncing contact: no key until a stable run.
        got.delete();
        for (int i = 0; i < 8; i++) begin
            pressed[2*4+3] = ~pressed[2*4+3];
            step(SD);
        end
        chk("bounce_none", got.size(), 0);
        pressed[2*4+3] = 1'b1;
        finish_press("bounce", 4'hC);

        for (int i = 0; i < 8; i++) begin
            int c;
            logic [3:0] m;
            c = $urandom_range(0, 3);
            m = 4'($urandom_range(1, 15));
            press_test($sformatf("rand%0d", i), m, c);
        end

        // Unconsumed key overwritten by a second press.
        key_ready = 1'b0;
        pressed[1*4+1] = 1'b1;
        step(40);
        chk("ovr_first_valid", key_valid, 1);
        chk("ovr_first_code", key_code, 4'h5);
        chk("ovr_first_flag", overrun, 0);
        pressed = 16'h0;
        step(40);
        pressed[2*4+2] = 1'b1;
        step(40);
        chk("ovr_code", key_code, 4'h9);
        chk("ovr_valid", key_valid, 1);
        chk("ovr_flag", overrun, 1);
        pressed = 16'h0;
        step(40);
        got.delete();
        key_ready = 1'b1;
        step(2);
        chk("ovr_drain_valid", key_valid, 0);
        chk("ovr_drain_code", (got.size() == 1) ? got[0] : 4'hx, 4'h9);
        chk("ovr_sticky", overrun, 1);

        // Reset in the middle of a press debounce.
        clr_n = 1'b0;
        step(2);
        chk("rst2_overrun", overrun, 0);
        clr_n = 1'b1;
        step(2);
        wait_col(1);
        pressed[1*4+0] = 1'b1;
        wait_col(0);
        step(SD + 2);
        clr_n = 1'b0;
        step(1);
        chk("mid_col", col_n, 4'b1110);
        chk("mid_valid", key_valid, 0);
        chk("mid_held", key_held, 0);
        chk("mid_code", key_code, 0);
        chk("mid_overrun", overrun, 0);
        got.delete();
        pressed = 16'h0;
        step(3);
        clr_n = 1'b1;
        step(60);
        chk("mid_no_key", got.size(), 0);
        chk("mid_no_valid", key_valid, 0);
        press_test("after_rst", 4'b0010, 3);

        // Long hold of key A.
        got.delete();
        pressed[0*4+3] = 1'b1;
        step(40 * SD);
        pressed = 16'h0;
        step(40);
`ifdef KEYPAD_REPEAT_EN
        chk("hold_count", (got.size() >= 2), 1);
`else
        chk("hold_count", got.size(), 1);
`endif
        for (int i = 0; i < got.size(); i++)
            chk("hold_code", got[i], 4'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
